// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types for the key-schedule blocks.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam byte_t RCON [1:NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for round r; zero outside 1..NR so the lookup never goes out of range.
  function automatic byte_t rcon_of(input logic [3:0] r);
    byte_t rc;
    rc = 8'h00;
    for (int i = 1; i <= NR; i++) begin
      if (r == 4'(i)) rc = RCON[i];
    end
    return rc;
  endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backward step of the AES-128 key schedule: round key r -> round key r-1.
module aes_inv_key_step
  import aes_pkg::*;
(
  input  logic [127:0] roundkey,
  input  logic [7:0]   rcon,
  output logic [127:0] prev_key
);

  word_t w0, w1, w2, w3;
  word_t p0, p1, p2, p3;
  word_t rot, sub;

  assign {w0, w1, w2, w3} = roundkey;

  // The forward schedule XOR-chains words left to right, so undoing it
  // recovers p3..p1 first; p0 then needs SubWord of the recovered p3.
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = rot_word(p3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .y (sub[8*i +: 8])
    );
  end

  assign p0       = w0 ^ sub ^ {rcon, 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 sits in the most significant byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_inv_keyexpansion.sv
// Inverse AES-128 key schedule: emits round keys 10 down to 0, one per next strobe.
module aes_inv_keyexpansion
  import aes_pkg::*;
(
  input  logic         int_osc,
  input  logic         reset,
  input  logic         load,
  input  logic [127:0] lastkey,
  input  logic         next,
  output logic [127:0] roundkey,
  output logic [3:0]   round,
  output logic         valid,
  output logic         done
);

  state_t       state_q, state_d;
  logic [127:0] key_d;
  logic [3:0]   round_d;
  logic [127:0] prev_key;
  logic [7:0]   rcon;
  logic         valid_d;

  assign rcon = rcon_of(round);

  aes_inv_key_step u_step (
    .roundkey (roundkey),
    .rcon     (rcon),
    .prev_key (prev_key)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d = state_q;
    key_d   = roundkey;
    round_d = round;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = ACTIVE;
          key_d   = lastkey;
          round_d = 4'(NR);
        end
      end
      ACTIVE: begin
        if (load) begin
          key_d   = lastkey;
          round_d = 4'(NR);
        end else if (next) begin
          if (round != 4'd0) begin
            key_d   = prev_key;
            round_d = round - 4'd1;
          end else begin
            // Schedule exhausted; roundkey keeps its stale value.
            state_d = IDLE;
            round_d = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == ACTIVE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      roundkey <= '0;
      round    <= 4'd0;
      valid    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      roundkey <= key_d;
      round    <= round_d;
      valid    <= valid_d;
      done     <= valid_d && (round_d == 4'd0);
    end
  end

endmodule

// File: doc/aes_inv_keyexpansion.md
Name: aes_inv_keyexpansion

Overview:
- Inverse AES-128 key schedule: takes the final (round-10) round key and produces round keys 10 down to 0, one per step.
- Companion to the forward key expansion FSM.
- Feeds the lab7 decryption datapath on the fly, so no 11x128-bit key storage is needed.
- Pacing is set by the consumer through a per-step `next` strobe.

Parameters:
- None. Round count (NR=10) and the Rcon table are fixed constants in the shared package.

Ports:
- int_osc  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  capture lastkey and restart the schedule at round 10.
- lastkey  input  128  round-10 key; word w0 = [127:96], w3 = [31:0].
- next  input  1  consumer strobe: step to the previous round key.
- roundkey  output  128  current round key, registered.
- round  output  4  index of the key on roundkey (10..0), registered.
- valid  output  1  roundkey/round are meaningful.
- done  output  1  high while valid and round == 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, roundkey=0, round=0, valid=0, done=0.
  - Takes effect immediately, including mid-schedule. Outputs stay at reset values until a load after reset is released.
- States are IDLE and ACTIVE. All outputs come from registers; there is no combinational path from inputs to outputs.
- IDLE:
  - valid=0, done=0.
  - load=1 → next cycle: roundkey=lastkey, round=10, valid=1, state=ACTIVE.
  - next is ignored.
- ACTIVE, load=1:
  - Recapture lastkey, round=10. Load has priority over next when both are high.
- ACTIVE, next=1 and round>0:
  - One cycle latency: roundkey ← prev(roundkey, Rcon[round]), round ← round-1.
  - Back-to-back next strobes produce one new key per cycle.
- ACTIVE, next=1 and round==0:
  - state=IDLE, valid=0, done=0, round=0.
  - roundkey holds its last value (don't-care to consumers).
- ACTIVE, neither load nor next:
  - All outputs hold.
- done = valid & (round==0), registered alongside round.
- prev() definition, with current words w0..w3 and previous words p0..p3:
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0}
  - RotWord rotates left one byte: {b1,b2,b3,b0}.
  - SubWord applies the forward AES S-box to each byte.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36, indexed by the current round r (before decrement).
- The S-box is combinational, with 4 instances. The full prev() computation completes in one cycle.
- round never wraps below 0 and never exceeds 10.

Decomposition:
- aes_pkg:
  - NR=10 constant.
  - RCON[1:10] byte array.
  - state enum {IDLE, ACTIVE}.
  - 32-bit word typedef.
  - RotWord function.
- Sub-module aes_inv_key_step: purely combinational, (roundkey, rcon) → prev key, instantiates 4x sbox.
- Top module holds only the FSM, the round counter and the output registers.

Test Plan:
1. Reset and load:
   - Hold reset=0 for 2 cycles, then release → roundkey=0, round=0, valid=0, done=0.
   - Pulse load with lastkey=D014F9A8C9EE2589E13F0CC8B6630CA6 → next cycle round=10, valid=1, roundkey=lastkey.
2. Single step from round 10:
   - One next pulse → round=9, roundkey=AC7766F319FADC2128D12941575C006E.
   - Hold next=0 for 5 cycles → roundkey and round unchanged.
3. Full schedule:
   - Ten back-to-back next cycles → round=1 gives A0FAFE1788542CB123A339392A6C7605.
   - round=0 gives 2B7E151628AED2A6ABF7158809CF4F3C with done=1.
   - One further next → valid=0, done=0, state IDLE.
4. Restart and priority:
   - At round=4, assert load and next in the same cycle → round=10, roundkey=lastkey; no step taken.
   - In IDLE, next alone → no change, valid stays 0.
5. Reset mid-operation:
   - Drive reset=0 asynchronously between clock edges at round=6 → outputs clear immediately, without waiting for an edge.
   - After release, a new load starts cleanly at round 10.
6. Round-trip:
   - Run the forward keyexpansion on key 2B7E151628AED2A6ABF7158809CF4F3C and feed its round-10 output as lastkey.
   - Round keys 10..0 from this block must match the forward round keys in reverse order.
